// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in/parallel-out deserializer with its own bit counter, selectable bit
// order and a single-word output holding register with a valid/ready handshake.
// Every WIDTH accepted serial bits form one word. That word is presented on
// pdata/pdata_valid on the same edge that samples its last bit.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: first received bit ends in pdata[WIDTH-1]; 0: in pdata[0]
//   INIT       reset value of the shift register
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   si_en        serial bit enable (si sampled only when high)
//   si           serial data in
//   sync         frame restart: drops the partial frame, restarts the bit count
//   so           serial out, the oldest bit in the shift register (combinational)
//   pdata        last completed word (registered)
//   pdata_valid  pdata holds a word that has not been consumed
//   pdata_ready  consumer takes pdata on an edge where pdata_valid is high
//   overrun      sticky: a completed word was dropped because pdata was full
//   clr_ovr      synchronous clear of overrun (a new overrun wins)
// -----------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si_en,
  input  logic             si,
  input  logic             sync,
  output logic             so,
  output logic [WIDTH-1:0] pdata,
  output logic             pdata_valid,
  input  logic             pdata_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  // WIDTH=2 still needs a one-bit counter.
  localparam int            CW       = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] pdata_reg, pdata_next;
  logic             pdata_valid_reg, pdata_valid_next;
  logic             overrun_reg, overrun_next;

  logic [WIDTH-1:0] shift_next;
  logic             word_done;
  logic             hold_free;

  // Shifted value of q with si entering at the end chosen by MSB_FIRST.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign shift_next[gi] = si;
        end else begin : g_mv
          assign shift_next[gi] = q_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign shift_next[gi] = si;
        end else begin : g_mv
          assign shift_next[gi] = q_reg[gi+1];
        end
      end
    end
  endgenerate

  // Shift register and bit counter. A sync that carries a bit makes that bit
  // the first of the new frame, so the count restarts at one, not zero.
  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    word_done = 1'b0;
    if (si_en) begin
      q_next = shift_next;
    end
    if (sync) begin
      cnt_next = si_en ? CNT_ONE : '0;
    end else if (si_en) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next  = '0;
        word_done = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_ONE;
      end
    end
  end

  // The holding register can take a new word if it is empty or is being
  // consumed on this same edge.
  assign hold_free = !pdata_valid_reg || pdata_ready;

  always_comb begin
    pdata_next       = pdata_reg;
    pdata_valid_next = pdata_valid_reg;
    overrun_next     = overrun_reg;
    if (word_done && hold_free) begin
      pdata_next       = q_next;
      pdata_valid_next = 1'b1;
    end else if (word_done) begin
      overrun_next = 1'b1;
    end else if (pdata_valid_reg && pdata_ready) begin
      pdata_valid_next = 1'b0;
    end
    // A new drop takes priority over the clear request.
    if (clr_ovr && !(word_done && !hold_free)) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg           <= INIT;
      cnt_reg         <= '0;
      pdata_reg       <= '0;
      pdata_valid_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      q_reg           <= q_next;
      cnt_reg         <= cnt_next;
      pdata_reg       <= pdata_next;
      pdata_valid_reg <= pdata_valid_next;
      overrun_reg     <= overrun_next;
    end
  end

  assign so          = MSB_FIRST ? q_reg[WIDTH-1] : q_reg[0];
  assign pdata       = pdata_reg;
  assign pdata_valid = pdata_valid_reg;
  assign overrun     = overrun_reg;

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in/parallel-out deserializer with automatic frame counting, selectable bit order, and a one-word output holding register with valid/ready handshake. It counts incoming bits and presents each complete WIDTH-bit word on a handshaked parallel port, so the downstream logic no longer needs an external word-strobe. It sits between serial converter interfaces (ADC/DAC links in the sine-wave datapath) and the parallel processing logic.

## Interface
Parameters:
- WIDTH, default 8, word length in bits; legal values are WIDTH ≥ 2.
- MSB_FIRST, default 1. When 1, the first received bit lands in pdata[WIDTH-1]. When 0, the first received bit lands in pdata[0].
- INIT, default all ones ({WIDTH{1'b1}}), reset value of the internal shift register.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- si_en  input  1  serial-bit enable; the bit on si is sampled only when si_en=1.
- si  input  1  serial data in.
- sync  input  1  frame restart; discards the partial frame and resets the bit count.
- so  output  1  serial out. It is q[WIDTH-1] when MSB_FIRST=1 and q[0] when MSB_FIRST=0. It is combinational from q.
- pdata  output  WIDTH  last completed word, registered.
- pdata_valid  output  1  pdata holds an unconsumed word.
- pdata_ready  input  1  the consumer accepts pdata this cycle when pdata_valid=1.
- overrun  output  1  sticky flag: a completed word was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

## Operation
- Internal state:
  - shift register q[WIDTH-1:0];
  - bit counter cnt of width $clog2(WIDTH), range 0..WIDTH-1;
  - output register pdata, pdata_valid and overrun.
- Shift behaviour, on a cycle with si_en=1:
  - MSB_FIRST=1: q <= {q[WIDTH-2:0], si}.
  - MSB_FIRST=0: q <= {si, q[WIDTH-1:1]}.
  - Without si_en, q holds.
- Counting, on a cycle with si_en=1 and sync=0:
  - If cnt < WIDTH-1, cnt increments.
  - If cnt = WIDTH-1, the word is complete and cnt wraps to 0.
- Word completion:
  - The completed word is the next value of q, including the current bit.
  - If the holding register is free, the word is loaded into pdata and pdata_valid <= 1.
  - The holding register counts as free when pdata_valid=0, or when pdata_valid=1 and pdata_ready=1 in the same cycle.
  - Otherwise the word is dropped, pdata and pdata_valid hold, and overrun <= 1.
- Drain: if pdata_valid=1, pdata_ready=1 and no word completes, then pdata_valid <= 0 and pdata holds its value.
- sync behaviour:
  - sync=1 with si_en=0: cnt <= 0.
  - sync=1 with si_en=1: the bit is shifted in as bit 1 of the new frame and cnt <= 1.
  - The partial frame never produces an output word, and q is not cleared.
  - The output register and the handshake are unaffected by sync.
- overrun:
  - Set has priority over clr_ovr when both occur in the same cycle.
  - clr_ovr alone clears it on the next edge.
  - overrun never clears on its own.
- pdata_ready is ignored while pdata_valid=0.

## Timing
- Reset, asynchronous (on rst assertion, independent of clk):
  - q=INIT, cnt=0, pdata=0, pdata_valid=0, overrun=0.
  - so therefore shows INIT[WIDTH-1] (MSB_FIRST=1) or INIT[0] (MSB_FIRST=0).
- Reset mid-frame discards all partial data. The first si_en after rst deassertion is bit 1 of a frame.
- Latency: pdata and pdata_valid update on the same clock edge that samples the last bit.
- Throughput: one word per WIDTH si_en cycles, with si_en allowed back-to-back. Sustained full rate requires pdata_ready=1 on the completion cycle, or on any cycle before it.
- Handshake: the transfer occurs on an edge where pdata_valid=1 and pdata_ready=1. pdata is stable while pdata_valid=1 and pdata_ready=0.
- WIDTH=2 edge case: the counter still needs a width of at least 1 bit.

## Test plan
- Basic MSB-first capture:
  - Stimulus: WIDTH=8, MSB_FIRST=1, pdata_ready=1; shift bits 1,0,1,0,0,1,0,1 on consecutive si_en.
  - Required: pdata=0xA5 and pdata_valid=1 on the 8th edge; pdata_valid=0 one cycle later.
- LSB-first capture:
  - Stimulus: MSB_FIRST=0; shift 1,0,1,0,0,1,0,1.
  - Required: pdata=0xA5, and so tracks q[0].
- Backpressure overrun:
  - Stimulus: pdata_ready=0; shift 0x3C then 0xC3.
  - Required: pdata stays 0x3C and overrun=1 after the 16th bit.
  - Then: clr_ovr=1 clears overrun, and ready=1 drains the 0x3C word.
- Same-cycle drain and refill:
  - Stimulus: pdata_valid=1 with 0x11 held; pdata_ready=1 exactly on the last bit of 0x22.
  - Required: pdata=0x22, pdata_valid stays 1, overrun stays 0.
- Sync mid-frame:
  - Stimulus: shift 3 bits; pulse sync with si_en=1 carrying the first bit of 0x81; then shift the remaining 7 bits.
  - Required: exactly one word, pdata=0x81.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 5 bits.
  - Required: all outputs zero immediately and so=1. A following full frame 0x5A yields pdata=0x5A.
